// File: rtl/multiport_reg_file_pkg.sv
// Shared constants for the multiport integer register file: XLEN encodings,
// architectural register count and register address width.
package multiport_reg_file_pkg;

  localparam logic [1:0] XLEN_32B   = 2'd1;
  localparam logic [1:0] XLEN_64B   = 2'd2;
  localparam int         RF_REG_CNT = 32;
  localparam int         RF_ADDR_W  = 5;

  function automatic int xlen_dw(input logic [1:0] xlen);
    return 1 << (int'(xlen) + 4);
  endfunction

endpackage

// File: rtl/multiport_reg_file_if.sv
// Decode-stage register file bus: read ports, writeback ports, issue and scoreboard.
// master = decode/issue/writeback side, slave = register file.
interface multiport_reg_file_if #(
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int DW     = 64
);
  import multiport_reg_file_pkg::*;

  logic [NUM_RD-1:0][RF_ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DW-1:0]        rd_data;
  logic [NUM_RD-1:0]                rd_busy;
  logic [NUM_WR-1:0]                wr_en;
  logic [NUM_WR-1:0][RF_ADDR_W-1:0] wr_addr;
  logic [NUM_WR-1:0][DW-1:0]        wr_data;
  logic                             issue_valid;
  logic [RF_ADDR_W-1:0]             issue_rd;
  logic [RF_REG_CNT-1:0]            busy_vec;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, issue_valid, issue_rd,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, issue_valid, issue_rd,
    output rd_data, rd_busy, busy_vec
  );

endinterface

// File: rtl/multiport_reg_file_scoreboard.sv
// Per-register busy scoreboard: writeback clears, issue sets, set wins on a tie.
// Register 0 is never marked busy.
module rf_scoreboard
  import multiport_reg_file_pkg::*;
#(
  parameter int NUM_WR  = 2,
  parameter int REG_CNT = RF_REG_CNT
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_clk_enable,
  input  logic [NUM_WR-1:0]                i_wr_en,
  input  logic [NUM_WR-1:0][RF_ADDR_W-1:0] i_wr_addr,
  input  logic                             i_issue_valid,
  input  logic [RF_ADDR_W-1:0]             i_issue_rd,
  output logic [REG_CNT-1:0]               o_busy_vec
);

  logic [REG_CNT-1:0] busy_q, busy_nxt;

  // Clears first, then the issue set, so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NUM_WR; w++)
      if (i_wr_en[w]) busy_nxt[i_wr_addr[w]] = 1'b0;
    if (i_issue_valid) busy_nxt[i_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)          busy_q <= '0;
    else if (i_clk_enable) busy_q <= busy_nxt;
  end

  assign o_busy_vec = busy_q;

endmodule

// File: rtl/multiport_reg_file.sv
// Parametrised multi-read/multi-write integer register file with busy scoreboard.
// Define MULTIPORT_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module multiport_reg_file
  import multiport_reg_file_pkg::*;
#(
  parameter logic [1:0] XLEN    = XLEN_64B,
  parameter int         NUM_RD  = 2,
  parameter int         NUM_WR  = 2,
  parameter int         REG_CNT = RF_REG_CNT,
  localparam int        DW      = xlen_dw(XLEN)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clk_enable,
  multiport_reg_file_if.slave bus
);

  logic [REG_CNT-1:0][DW-1:0] regs;

  // Ascending port loop: the last non-blocking write wins, so the highest port
  // index takes a collision. Entry 0 is never written and stays zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      regs <= '0;
    end else if (i_clk_enable) begin
      for (int w = 0; w < NUM_WR; w++)
        if (bus.wr_en[w] && bus.wr_addr[w] != '0)
          regs[bus.wr_addr[w]] <= bus.wr_data[w];
    end
  end

  rf_scoreboard #(
    .NUM_WR  (NUM_WR),
    .REG_CNT (REG_CNT)
  ) u_scoreboard (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_clk_enable  (i_clk_enable),
    .i_wr_en       (bus.wr_en),
    .i_wr_addr     (bus.wr_addr),
    .i_issue_valid (bus.issue_valid),
    .i_issue_rd    (bus.issue_rd),
    .o_busy_vec    (bus.busy_vec)
  );

`ifdef MULTIPORT_RF_BYPASS_EN
  // Gated by reset too, so outputs read zero while reset is held.
  logic byp_en;
  assign byp_en = i_clk_enable && i_rst_n;
`endif

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [RF_ADDR_W-1:0] addr;
    logic [DW-1:0]        val;
    logic                 bsy;

    assign addr = bus.rd_addr[k];

    always_comb begin
      val = regs[addr];
      bsy = bus.busy_vec[addr];
`ifdef MULTIPORT_RF_BYPASS_EN
      for (int w = 0; w < NUM_WR; w++)
        if (byp_en && bus.wr_en[w] && bus.wr_addr[w] == addr && addr != '0) begin
          val = bus.wr_data[w];
          bsy = 1'b0;
        end
`endif
    end

    assign bus.rd_data[k] = val;
    assign bus.rd_busy[k] = bsy;
  end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Scoreboard bench for multiport_reg_file: stimulus queues expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_multiport_reg_file;
  import multiport_reg_file_pkg::*;

  localparam int NUM_RD = 2;
  localparam int NUM_WR = 2;
  localparam int DW     = 64;
`ifdef MULTIPORT_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    int          kind;   // 0 rd_data[idx], 1 rd_busy[idx], 2 busy_vec
    int          idx;
    logic [63:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clk_en;
  exp_t exp_q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  multiport_reg_file_if #(.NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .DW(DW)) bus ();

  multiport_reg_file #(
    .XLEN   (XLEN_64B),
    .NUM_RD (NUM_RD),
    .NUM_WR (NUM_WR)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_clk_enable (clk_en),
    .bus          (bus)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en       = '0;
    bus.issue_valid = 1'b0;
  endtask

  task automatic wr(input int p, input int a, input logic [63:0] d);
    bus.wr_en[p]   = 1'b1;
    bus.wr_addr[p] = RF_ADDR_W'(a);
    bus.wr_data[p] = d;
  endtask

  task automatic issue(input int a);
    bus.issue_valid = 1'b1;
    bus.issue_rd    = RF_ADDR_W'(a);
  endtask

  task automatic expect_(input int kind, input int idx, input logic [63:0] val, input string name);
    exp_t e;
    e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [63:0] act;
      e = exp_q.pop_front();
      case (e.kind)
        0:       act = bus.rd_data[e.idx];
        1:       act = 64'(bus.rd_busy[e.idx]);
        default: act = 64'(bus.busy_vec);
      endcase
      checks++;
      if (act === e.val) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.val);
    end
  end

  initial begin
    rst_n = 1'b0;
    clk_en = 1'b1;
    bus.rd_addr = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.issue_rd = '0;
    idle();
    repeat (2) cyc();
    expect_(0, 0, 64'h0, "reset_rd0");
    expect_(1, 0, 64'h0, "reset_rdbusy0");
    expect_(2, 0, 64'h0, "reset_busyvec");

    // write x5 and mark it busy, then pulse reset mid-cycle
    cyc(); rst_n = 1'b1;
    cyc(); wr(0, 5, 64'h1234); issue(5);
    cyc(); idle(); bus.rd_addr[0] = 5'd5;
    expect_(0, 0, 64'h1234, "x5_stored");
    expect_(1, 0, 64'h1, "x5_busy");
    expect_(2, 0, 64'h20, "busyvec_x5");
    cyc(); rst_n = 1'b0;
    expect_(0, 0, 64'h0, "midreset_x5");
    expect_(1, 0, 64'h0, "midreset_rdbusy");
    expect_(2, 0, 64'h0, "midreset_busyvec");

    // x0 protection
    cyc(); rst_n = 1'b1; wr(0, 0, 64'hFFFF); issue(0); bus.rd_addr[0] = 5'd0;
    expect_(0, 0, 64'h0, "x0_same_cycle");
    cyc(); idle();
    expect_(0, 0, 64'h0, "x0_after");
    expect_(2, 0, 64'h0, "x0_busyvec");

    // write collision on x7, both read ports on x7
    cyc(); wr(0, 7, 64'hAAAA); wr(1, 7, 64'hBBBB);
    bus.rd_addr[0] = 5'd7; bus.rd_addr[1] = 5'd7;
    expect_(0, 0, BYP ? 64'hBBBB : 64'h0, "coll_same_rd0");
    expect_(0, 1, BYP ? 64'hBBBB : 64'h0, "coll_same_rd1");
    cyc(); idle();
    expect_(0, 0, 64'hBBBB, "coll_rd0");
    expect_(0, 1, 64'hBBBB, "coll_rd1");

    // write x3 while port1 reads it and x3 is busy
    cyc(); issue(3);
    cyc(); idle(); wr(0, 3, 64'h55); bus.rd_addr[1] = 5'd3;
    expect_(0, 1, BYP ? 64'h55 : 64'h0, "byp_data");
    expect_(1, 1, BYP ? 64'h0 : 64'h1, "byp_busy");
    expect_(2, 0, 64'h8, "byp_busyvec");
    cyc(); idle();
    expect_(0, 1, 64'h55, "x3_after");
    expect_(1, 1, 64'h0, "x3_busy_after");
    expect_(2, 0, 64'h0, "x3_busyvec_after");

    // scoreboard set/clear priority on x9
    cyc(); issue(9);
    cyc(); issue(9); wr(1, 9, 64'h99); bus.rd_addr[0] = 5'd9;
    expect_(2, 0, 64'h200, "sb_set");
    expect_(0, 0, BYP ? 64'h99 : 64'h0, "sb_rd_same");
    expect_(1, 0, BYP ? 64'h0 : 64'h1, "sb_rdbusy_same");
    cyc(); idle(); wr(1, 9, 64'h9A);
    expect_(2, 0, 64'h200, "sb_set_wins");
    expect_(0, 0, BYP ? 64'h9A : 64'h99, "sb_rd_x9");
    cyc(); idle();
    expect_(2, 0, 64'h0, "sb_cleared");
    expect_(0, 0, 64'h9A, "sb_x9_final");
    expect_(1, 0, 64'h0, "sb_rdbusy_final");

    // stall: nothing commits while clock enable is low
    cyc(); clk_en = 1'b0; wr(0, 4, 64'h77); wr(1, 7, 64'h1); issue(4);
    bus.rd_addr[0] = 5'd4; bus.rd_addr[1] = 5'd7;
    expect_(0, 0, 64'h0, "stall_same_x4");
    expect_(0, 1, 64'hBBBB, "stall_same_x7");
    expect_(1, 0, 64'h0, "stall_same_busy");
    cyc();
    expect_(0, 0, 64'h0, "stall_x4");
    expect_(0, 1, 64'hBBBB, "stall_x7");
    expect_(2, 0, 64'h0, "stall_busyvec");
    cyc(); clk_en = 1'b1; idle();
    expect_(0, 0, 64'h0, "post_stall_x4");
    expect_(2, 0, 64'h0, "post_stall_busyvec");

    for (int i = 0; i < 100 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
